// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: canonical NOP contents and the hazard sequencer state type.
package pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] NOP_PC   = 32'h0000_0000;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf.sv
// 32-bit wrapping event counter with enable and asynchronous clear.
module perf_counter32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    // Count enabled cycles, wrapping modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (en) begin
            count <= count + 32'd1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: drain after reset, load-use bubbles,
// EX redirects and memory freezes, with stall/flush counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        imem_ready,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        back_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
    output logic        mem_timeout
);

    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    ctrl_state_t   state_r;
    ctrl_state_t   state_nxt_s;
    logic [IW-1:0] init_cnt_r;
    logic [WW-1:0] wait_cnt_r;
    logic          mem_stall_s;
    logic          load_use_s;
    logic          redirect_fire_s;
    logic          stall_cnt_en_s;

    assign mem_stall_s = ~imem_ready | (dmem_req & ~dmem_ready);
    assign load_use_s  = ex_mem_read & (ex_rd != 5'd0) &
                         ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Enable/flush decode; INIT values are the defaults and drain NOPs through the pipe
    always_comb begin
        pc_we           = 1'b0;
        ifid_we         = 1'b1;
        idex_we         = 1'b1;
        back_we         = 1'b1;
        ifid_flush      = 1'b1;
        idex_flush      = 1'b1;
        redirect_fire_s = 1'b0;
        case (state_r)
            RUN, MEM_WAIT: begin
                if (mem_stall_s) begin
                    ifid_we    = 1'b0;
                    idex_we    = 1'b0;
                    back_we    = 1'b0;
                    ifid_flush = 1'b0;
                    idex_flush = 1'b0;
                end else if (ex_redirect) begin
                    // The squashed ID instruction makes any load-use hazard moot
                    pc_we           = 1'b1;
                    redirect_fire_s = 1'b1;
                end else if (load_use_s) begin
                    ifid_we    = 1'b0;
                    ifid_flush = 1'b0;
                end else begin
                    pc_we      = 1'b1;
                    ifid_flush = 1'b0;
                    idex_flush = 1'b0;
                end
            end
            default: begin
                pc_we = 1'b0;
            end
        endcase
    end

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            INIT: begin
                if (init_cnt_r == IW'(INIT_CYCLES - 1)) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            RUN, MEM_WAIT: begin
                if (mem_stall_s) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = INIT;
            end
        endcase
    end

    // State, drain counter, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= INIT;
            init_cnt_r  <= {IW{1'b0}};
            wait_cnt_r  <= {WW{1'b0}};
            mem_timeout <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == INIT) begin
                init_cnt_r <= init_cnt_r + IW'(1);
            end else begin
                init_cnt_r <= init_cnt_r;
            end
            if (state_r == RUN && mem_stall_s) begin
                wait_cnt_r <= WW'(1);
            end else if (state_r == MEM_WAIT && mem_stall_s) begin
                wait_cnt_r <= (wait_cnt_r == WW'(TIMEOUT)) ? wait_cnt_r : wait_cnt_r + WW'(1);
            end else begin
                wait_cnt_r <= {WW{1'b0}};
            end
            if (state_r == MEM_WAIT && mem_stall_s && wait_cnt_r == WW'(TIMEOUT - 1)) begin
                mem_timeout <= 1'b1;
            end else begin
                mem_timeout <= mem_timeout;
            end
        end
    end

    assign stall_cnt_en_s = (state_r != INIT) & ~pc_we;

    perf_counter32 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_cnt_en_s),
        .count (stall_cycles)
    );

    perf_counter32 u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (redirect_fire_s),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (INIT_CYCLES=2, TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
    logic        imem_ready, dmem_req, dmem_ready;
    logic        pc_we, ifid_we, idex_we, back_we, ifid_flush, idex_flush;
    logic [31:0] stall_cycles, flush_events;
    logic        mem_timeout;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Output vector order: {pc_we, ifid_we, idex_we, back_we, ifid_flush, idex_flush}
    localparam logic [5:0] O_INIT   = 6'b011111;
    localparam logic [5:0] O_NORM   = 6'b111100;
    localparam logic [5:0] O_BUBBLE = 6'b001101;
    localparam logic [5:0] O_REDIR  = 6'b111111;
    localparam logic [5:0] O_FREEZE = 6'b000000;

    pipeline_hazard_ctrl #(.INIT_CYCLES(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .back_we(back_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {pc_we, ifid_we, idex_we, back_we, ifid_flush, idex_flush};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    endtask

    // Reset and walk through the two drain cycles into RUN
    task automatic do_reset(input bit verbose);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        if (verbose) begin
            check_val("init0_outs", 32'(outs()), 32'(O_INIT));
            check_val("init0_stall", stall_cycles, 32'd0);
            check_val("init0_flush", flush_events, 32'd0);
            check_val("init0_tmo", 32'(mem_timeout), 32'd0);
        end
        tick(); #1;
        if (verbose) check_val("init1_outs", 32'(outs()), 32'(O_INIT));
        tick(); #1;
        check_val("run_outs", 32'(outs()), 32'(O_NORM));
    endtask

    initial begin
        do_reset(1'b1);

        // Load-use: one bubble, then normal flow
        set_load_use(); #1;
        check_val("lu_outs", 32'(outs()), 32'(O_BUBBLE));
        tick();
        ex_mem_read = 1'b0; #1;
        check_val("lu_next_outs", 32'(outs()), 32'(O_NORM));
        check_val("lu_stall", stall_cycles, 32'd1);

        // Load to x0 never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; id_rs2 = 5'd0; #1;
        check_val("x0_outs", 32'(outs()), 32'(O_NORM));
        tick();
        idle_inputs(); #1;
        check_val("x0_stall", stall_cycles, 32'd1);

        // Redirect overrides load-use
        set_load_use(); ex_redirect = 1'b1; #1;
        check_val("rd_lu_outs", 32'(outs()), 32'(O_REDIR));
        tick();
        idle_inputs(); #1;
        check_val("rd_lu_flush", flush_events, 32'd1);
        check_val("rd_lu_stall", stall_cycles, 32'd1);

        // Data memory freeze with a pending redirect
        do_reset(1'b0);
        dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_val($sformatf("frz_outs%0d", i), 32'(outs()), 32'(O_FREEZE));
            tick();
        end
        dmem_ready = 1'b1; #1;
        check_val("frz_redir_outs", 32'(outs()), 32'(O_REDIR));
        tick();
        idle_inputs(); #1;
        check_val("frz_stall", stall_cycles, 32'd3);
        check_val("frz_flush", flush_events, 32'd1);
        check_val("frz_tmo", 32'(mem_timeout), 32'd0);

        // Instruction memory timeout and its stickiness
        do_reset(1'b0);
        imem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 check_val($sformatf("tmo_c%0d", i), 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
            tick();
        end
        imem_ready = 1'b1; #1;
        check_val("tmo_stall", stall_cycles, 32'd6);
        check_val("tmo_after_outs", 32'(outs()), 32'(O_NORM));
        tick(); #1;
        check_val("tmo_sticky", 32'(mem_timeout), 32'd1);

        // Asynchronous reset from MEM_WAIT
        imem_ready = 1'b0;
        tick();
        rst = 1'b1; #1;
        check_val("arst_outs", 32'(outs()), 32'(O_INIT));
        check_val("arst_stall", stall_cycles, 32'd0);
        check_val("arst_flush", flush_events, 32'd0);
        check_val("arst_tmo", 32'(mem_timeout), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
